// File: rtl/alu_operand_select.sv
// Execute-stage operand/function selector for the Y86-64 SEQ core: registers the ALU operands, function and cc-enable.
// Optional macro ALU_OPSEL_IADDQ_EN makes icode C (iaddq) a legal instruction.
module alu_operand_select #(
   parameter int WORD_W  = 64,
   parameter int STK_INC = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [3:0]        icode,
   input  logic [3:0]        ifun,
   input  logic [WORD_W-1:0] valA,
   input  logic [WORD_W-1:0] valB,
   input  logic [WORD_W-1:0] valC,
   output logic              out_valid,
   output logic [WORD_W-1:0] aluA,
   output logic [WORD_W-1:0] aluB,
   output logic [1:0]        alufun,
   output logic              set_cc,
   output logic              op_err
);

   localparam logic signed [WORD_W-1:0] STK_POS = WORD_W'(STK_INC);
   localparam logic signed [WORD_W-1:0] STK_NEG = -STK_POS;

   logic [WORD_W-1:0] aluA_d, aluB_d, aluA_q, aluB_q;
   logic [1:0]        alufun_d, alufun_q;
   logic              set_cc_d, op_err_d, set_cc_q, op_err_q, out_valid_q;

   always_comb begin
      aluA_d   = '0;
      aluB_d   = '0;
      alufun_d = 2'd0;
      set_cc_d = 1'b0;
      op_err_d = 1'b0;
      case (icode)
         4'h0, 4'h1, 4'h7: ;
         4'h2: aluA_d = valA;
         4'h3: aluA_d = valC;
         4'h4, 4'h5: begin
            aluA_d = valC;
            aluB_d = valB;
         end
         4'h6: begin
            // Only ADD/SUB/AND/XOR exist; the upper ifun bits must be clear.
            if (ifun[3:2] != 2'b00) begin
               op_err_d = 1'b1;
            end else begin
               aluA_d   = valA;
               aluB_d   = valB;
               alufun_d = ifun[1:0];
               set_cc_d = 1'b1;
            end
         end
         4'h8, 4'hA: begin
            aluA_d = STK_NEG;
            aluB_d = valB;
         end
         4'h9, 4'hB: begin
            aluA_d = STK_POS;
            aluB_d = valB;
         end
`ifdef ALU_OPSEL_IADDQ_EN
         4'hC: begin
            aluA_d   = valC;
            aluB_d   = valB;
            set_cc_d = 1'b1;
         end
`endif
         default: op_err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         aluA_q      <= '0;
         aluB_q      <= '0;
         alufun_q    <= 2'd0;
         set_cc_q    <= 1'b0;
         op_err_q    <= 1'b0;
      end else if (in_valid) begin
         out_valid_q <= 1'b1;
         aluA_q      <= aluA_d;
         aluB_q      <= aluB_d;
         alufun_q    <= alufun_d;
         set_cc_q    <= set_cc_d;
         op_err_q    <= op_err_d;
      end else begin
         // Idle cycle: flags drop, operands keep their last values.
         out_valid_q <= 1'b0;
         set_cc_q    <= 1'b0;
         op_err_q    <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign aluA      = aluA_q;
   assign aluB      = aluB_q;
   assign alufun    = alufun_q;
   assign set_cc    = set_cc_q;
   assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_operand_select.sv
// Table-driven, scoreboard-checked bench for alu_operand_select (honours ALU_OPSEL_IADDQ_EN if defined).
module tb_alu_operand_select;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  icode, ifun;
   logic [63:0] valA, valB, valC;
   logic        out_valid, set_cc, op_err;
   logic [63:0] aluA, aluB;
   logic [1:0]  alufun;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        iv;
      logic [3:0]  ic, fn;
      logic [63:0] a, b, c;
      logic [63:0] eA, eB;
      logic [1:0]  eF;
      logic        eCC, eErr, eOV;
   } vec_t;

   typedef struct {
      logic [63:0] eA, eB;
      logic [1:0]  eF;
      logic        eCC, eErr, eOV;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;

   alu_operand_select #(.WORD_W(64), .STK_INC(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .icode(icode), .ifun(ifun),
      .valA(valA), .valB(valB), .valC(valC),
      .out_valid(out_valid), .aluA(aluA), .aluB(aluB),
      .alufun(alufun), .set_cc(set_cc), .op_err(op_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(e.eOV));
      check({tag, ".aluA"},      aluA,           e.eA);
      check({tag, ".aluB"},      aluB,           e.eB);
      check({tag, ".alufun"},    64'(alufun),    64'(e.eF));
      check({tag, ".set_cc"},    64'(set_cc),    64'(e.eCC));
      check({tag, ".op_err"},    64'(op_err),    64'(e.eErr));
   endtask

   task automatic add(input logic iv, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [63:0] eA, input logic [63:0] eB, input logic [1:0] eF,
                      input logic eCC, input logic eErr);
      vec_t v;
      v.iv = iv; v.ic = ic; v.fn = fn; v.a = a; v.b = b; v.c = c;
      v.eA = eA; v.eB = eB; v.eF = eF; v.eCC = eCC; v.eErr = eErr; v.eOV = iv;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      @(negedge clk);
      in_valid = v.iv; icode = v.ic; ifun = v.fn;
      valA = v.a; valB = v.b; valC = v.c;
      e.eA = v.eA; e.eB = v.eB; e.eF = v.eF; e.eCC = v.eCC; e.eErr = v.eErr; e.eOV = v.eOV;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("FAIL scoreboard: empty queue, expected 1 entry");
      end else begin
         check_all($sformatf("vec_ic%0h_fn%0h", v.ic, v.fn), sb.pop_front());
      end
   endtask

   initial begin
      exp_t z;
      z.eA = '0; z.eB = '0; z.eF = 2'd0; z.eCC = 1'b0; z.eErr = 1'b0; z.eOV = 1'b0;

      // iv ic fn valA valB valC | aluA aluB fun cc err
      add(1, 4'h2, 0, 64'h1234, 64'h99,  64'h77,   64'h1234, 64'h0,   2'd0, 0, 0);
      add(1, 4'h6, 1, 64'h5,    64'h9,   64'h0,    64'h5,    64'h9,   2'd1, 1, 0);
      add(1, 4'h6, 3, 64'h5,    64'h9,   64'h0,    64'h5,    64'h9,   2'd3, 1, 0);
      add(0, 4'h9, 0, 64'hdead, 64'hbeef,64'h1,    64'h5,    64'h9,   2'd3, 0, 0);
      add(1, 4'hA, 0, 64'h11,   64'h100, 64'h22,   NEG8,     64'h100, 2'd0, 0, 0);
      add(1, 4'hB, 0, 64'h11,   64'h100, 64'h22,   64'h8,    64'h100, 2'd0, 0, 0);
      add(1, 4'h5, 0, 64'h3,    64'h200, 64'h40,   64'h40,   64'h200, 2'd0, 0, 0);
      add(1, 4'h3, 0, 64'h1,    64'h2,   64'hABCD, 64'hABCD, 64'h0,   2'd0, 0, 0);
      add(1, 4'h4, 0, 64'h1,    64'h20,  64'h10,   64'h10,   64'h20,  2'd0, 0, 0);
      add(1, 4'h8, 0, 64'h1,    64'h300, 64'h5,    NEG8,     64'h300, 2'd0, 0, 0);
      add(1, 4'h9, 0, 64'h1,    64'h400, 64'h5,    64'h8,    64'h400, 2'd0, 0, 0);
      add(1, 4'h6, 2, 64'hF0,   64'h0F,  64'h0,    64'hF0,   64'h0F,  2'd2, 1, 0);
      add(1, 4'h6, 5, 64'h7,    64'h8,   64'h0,    64'h0,    64'h0,   2'd0, 0, 1);
      add(1, 4'h6, 0, 64'h7,    64'h8,   64'h0,    64'h7,    64'h8,   2'd0, 1, 0);
      add(1, 4'h6, 8, 64'h7,    64'h8,   64'h0,    64'h0,    64'h0,   2'd0, 0, 1);
      add(1, 4'h0, 3, 64'hAA,   64'hBB,  64'hCC,   64'h0,    64'h0,   2'd0, 0, 0);
      add(1, 4'h1, 0, 64'hAA,   64'hBB,  64'hCC,   64'h0,    64'h0,   2'd0, 0, 0);
      add(1, 4'h7, 2, 64'hAA,   64'hBB,  64'hCC,   64'h0,    64'h0,   2'd0, 0, 0);
`ifdef ALU_OPSEL_IADDQ_EN
      add(1, 4'hC, 0, 64'h1,    64'h66,  64'h55,   64'h55,   64'h66,  2'd0, 1, 0);
`else
      add(1, 4'hC, 0, 64'h1,    64'h66,  64'h55,   64'h0,    64'h0,   2'd0, 0, 1);
`endif
      add(1, 4'hD, 0, 64'h1,    64'h2,   64'h3,    64'h0,    64'h0,   2'd0, 0, 1);
      add(1, 4'h2, 0, 64'h8000_0000_0000_0001, 64'h2, 64'h3, 64'h8000_0000_0000_0001, 64'h0, 2'd0, 0, 0);
      add(1, 4'hF, 3, 64'h1,    64'h2,   64'h3,    64'h0,    64'h0,   2'd0, 0, 1);

      rst_n = 1'b0; in_valid = 1'b0; icode = '0; ifun = '0;
      valA = '0; valB = '0; valC = '0;
      #12;
      check_all("reset", z);

      @(negedge clk);
      rst_n = 1'b1;
      foreach (vecs[i]) drive(vecs[i]);

      // Asynchronous reset asserted mid-cycle clears outputs without a clock edge.
      @(negedge clk);
      in_valid = 1'b1; icode = 4'h6; ifun = 4'h1; valA = 64'h77; valB = 64'h88;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", z);

      // Reset held across an edge with valid inputs: the in-flight op is discarded.
      @(posedge clk);
      #1;
      check_all("rst_hold", z);

      // Release with in_valid low: nothing is captured.
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all("idle_after_rst", z);

      // First valid op after release is captured at the next edge.
      begin
         vec_t v;
         v.iv = 1; v.ic = 4'hB; v.fn = 0; v.a = 0; v.b = 64'h5000; v.c = 0;
         v.eA = 64'h8; v.eB = 64'h5000; v.eF = 0; v.eCC = 0; v.eErr = 0; v.eOV = 1;
         drive(v);
      end
      @(negedge clk);
      in_valid = 1'b0;

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
